// File: rtl/dll_tx_scheduler_if.sv
// Handshake bundle between the Transaction Layer / RX Ack path and the DLL TX
// scheduler, plus the scheduler's packetizer-facing beat stream and status.
interface dll_tx_scheduler_if #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int SEQ_WIDTH       = 12
);
  logic                       link_up_i;
  logic                       tlp_valid_i;
  logic                       tlp_ready_o;
  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i;
  logic                       tlp_sop_i;
  logic                       tlp_eop_i;
  logic                       dllp_valid_i;
  logic                       dllp_ready_o;
  logic [63:0]                dllp_data_i;
  logic                       ack_valid_i;
  logic [SEQ_WIDTH-1:0]       ack_seq_i;
  logic                       pkt_valid_o;
  logic                       pkt_ready_i;
  logic [PIPE_DATA_WIDTH-1:0] pkt_data_o;
  logic                       pkt_sop_o;
  logic                       pkt_eop_o;
  logic                       pkt_is_tlp_o;
  logic [SEQ_WIDTH-1:0]       pkt_seq_o;
  logic [SEQ_WIDTH-1:0]       outstanding_o;
  logic                       proto_err_o;

  modport slave (
    input  link_up_i, tlp_valid_i, tlp_data_i, tlp_sop_i, tlp_eop_i,
           dllp_valid_i, dllp_data_i, ack_valid_i, ack_seq_i, pkt_ready_i,
    output tlp_ready_o, dllp_ready_o, pkt_valid_o, pkt_data_o, pkt_sop_o,
           pkt_eop_o, pkt_is_tlp_o, pkt_seq_o, outstanding_o, proto_err_o
  );

  modport master (
    output link_up_i, tlp_valid_i, tlp_data_i, tlp_sop_i, tlp_eop_i,
           dllp_valid_i, dllp_data_i, ack_valid_i, ack_seq_i, pkt_ready_i,
    input  tlp_ready_o, dllp_ready_o, pkt_valid_o, pkt_data_o, pkt_sop_o,
           pkt_eop_o, pkt_is_tlp_o, pkt_seq_o, outstanding_o, proto_err_o
  );
endinterface

// File: rtl/dll_tx_scheduler.sv
// DLL transmit scheduler: arbitrates multi-beat TLPs against single-beat DLLPs
// onto one registered beat stream, numbers TLPs, and throttles new TLPs while
// the replay window is full. Acks retire window entries.
module dll_tx_scheduler #(
  parameter int PIPE_DATA_WIDTH   = 256,
  parameter int SEQ_WIDTH         = 12,
  parameter int MAX_OUTSTANDING   = 64,
  parameter int DLLP_STARVE_LIMIT = 4
) (
  input  logic                 sclk,
  input  logic                 srst_n,
  dll_tx_scheduler_if.slave    bus
);

  localparam int STARVE_W = $clog2(DLLP_STARVE_LIMIT + 1);
  localparam logic [SEQ_WIDTH-1:0] MAX_OUT    = SEQ_WIDTH'(MAX_OUTSTANDING);
  localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(DLLP_STARVE_LIMIT);
  localparam logic [SEQ_WIDTH-1:0] SEQ_ONE    = SEQ_WIDTH'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_TLP  = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_nextState;

  logic                       r_pktValid;
  logic [PIPE_DATA_WIDTH-1:0] r_pktData;
  logic                       r_pktSop;
  logic                       r_pktEop;
  logic                       r_pktIsTlp;
  logic [SEQ_WIDTH-1:0]       r_pktSeq;
  logic                       r_protoErr;
  logic [SEQ_WIDTH-1:0]       r_nextSeq;
  logic [SEQ_WIDTH-1:0]       r_ackedSeq;
  logic [SEQ_WIDTH-1:0]       r_curSeq;
  logic [STARVE_W-1:0]        r_starve;

  logic                       w_active;
  logic                       w_regFree;
  logic [SEQ_WIDTH-1:0]       w_outstanding;
  logic                       w_tlpStart;
  logic [SEQ_WIDTH-1:0]       w_ackDist;
  logic                       w_ackOk;
  logic                       w_tlpReady;
  logic                       w_dllpReady;
  logic                       w_dllpGrant;
  logic                       w_sopGrant;
  logic                       w_midBeat;
  logic                       w_protoErr;

  // The window count is derived from the two sequence pointers so it can never
  // drift from them; after reset 0 - 4095 - 1 wraps to 0.
  assign w_active      = srst_n & bus.link_up_i;
  assign w_regFree     = !r_pktValid || bus.pkt_ready_i;
  assign w_outstanding = r_nextSeq - r_ackedSeq - SEQ_ONE;
  assign w_tlpStart    = bus.tlp_valid_i & bus.tlp_sop_i & (w_outstanding < MAX_OUT);
  assign w_ackDist     = r_nextSeq - SEQ_ONE - bus.ack_seq_i;
  assign w_ackOk       = bus.ack_valid_i & (w_ackDist < w_outstanding);

  // State register; dropping the link always returns to the packet boundary.
  always_ff @(posedge sclk) begin
    if (!srst_n) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  // Arbitration and handshake decode: stray beats first, then DLLP unless the
  // starve limit hands the slot to a waiting TLP start.
  always_comb begin
    w_nextState = r_state;
    w_tlpReady  = 1'b0;
    w_dllpReady = 1'b0;
    w_dllpGrant = 1'b0;
    w_sopGrant  = 1'b0;
    w_midBeat   = 1'b0;
    w_protoErr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_active && w_regFree) begin
          if (bus.tlp_valid_i && !bus.tlp_sop_i) begin
            w_tlpReady = 1'b1;
            w_protoErr = 1'b1;
          end else if (bus.dllp_valid_i && !(w_tlpStart && r_starve == STARVE_MAX)) begin
            w_dllpReady = 1'b1;
            w_dllpGrant = 1'b1;
          end else if (w_tlpStart) begin
            w_tlpReady = 1'b1;
            w_sopGrant = 1'b1;
            if (!bus.tlp_eop_i) w_nextState = S_TLP;
          end
        end
      end
      S_TLP: begin
        w_tlpReady = w_active && w_regFree;
        if (w_tlpReady && bus.tlp_valid_i) begin
          w_midBeat  = 1'b1;
          w_protoErr = bus.tlp_sop_i;
          if (bus.tlp_eop_i) w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
    if (!bus.link_up_i) w_nextState = S_IDLE;
  end

  // Output beat register: loads on any grant, otherwise empties once taken and
  // holds its contents while the packetizer stalls.
  always_ff @(posedge sclk) begin
    if (!srst_n || !bus.link_up_i) begin
      r_pktValid <= 1'b0;
      r_pktData  <= '0;
      r_pktSop   <= 1'b0;
      r_pktEop   <= 1'b0;
      r_pktIsTlp <= 1'b0;
      r_pktSeq   <= '0;
    end else if (w_dllpGrant) begin
      r_pktValid <= 1'b1;
      r_pktData  <= PIPE_DATA_WIDTH'(bus.dllp_data_i);
      r_pktSop   <= 1'b1;
      r_pktEop   <= 1'b1;
      r_pktIsTlp <= 1'b0;
      r_pktSeq   <= '0;
    end else if (w_sopGrant) begin
      r_pktValid <= 1'b1;
      r_pktData  <= bus.tlp_data_i;
      r_pktSop   <= 1'b1;
      r_pktEop   <= bus.tlp_eop_i;
      r_pktIsTlp <= 1'b1;
      r_pktSeq   <= r_nextSeq;
    end else if (w_midBeat) begin
      r_pktValid <= 1'b1;
      r_pktData  <= bus.tlp_data_i;
      r_pktSop   <= 1'b0;
      r_pktEop   <= bus.tlp_eop_i;
      r_pktIsTlp <= 1'b1;
      r_pktSeq   <= r_curSeq;
    end else if (bus.pkt_ready_i) begin
      r_pktValid <= 1'b0;
    end
  end

  // Sequence bookkeeping: a TLP start consumes a number, an in-window Ack moves
  // the acked pointer; both may happen in the same cycle.
  always_ff @(posedge sclk) begin
    if (!srst_n || !bus.link_up_i) begin
      r_nextSeq  <= '0;
      r_ackedSeq <= '1;
      r_curSeq   <= '0;
    end else begin
      if (w_sopGrant) begin
        r_nextSeq <= r_nextSeq + SEQ_ONE;
        r_curSeq  <= r_nextSeq;
      end
      if (w_ackOk) r_ackedSeq <= bus.ack_seq_i;
    end
  end

  // Starvation counter: counts DLLP wins over a waiting TLP start.
  always_ff @(posedge sclk) begin
    if (!srst_n || !bus.link_up_i)      r_starve <= '0;
    else if (w_sopGrant || !w_tlpStart) r_starve <= '0;
    else if (w_dllpGrant && r_starve != STARVE_MAX) r_starve <= r_starve + 1'b1;
  end

  // Framing violations are flagged alongside the beat that carried them.
  always_ff @(posedge sclk) begin
    if (!srst_n || !bus.link_up_i) r_protoErr <= 1'b0;
    else                           r_protoErr <= w_protoErr;
  end

  assign bus.tlp_ready_o   = w_tlpReady;
  assign bus.dllp_ready_o  = w_dllpReady;
  assign bus.pkt_valid_o   = r_pktValid;
  assign bus.pkt_data_o    = r_pktData;
  assign bus.pkt_sop_o     = r_pktSop;
  assign bus.pkt_eop_o     = r_pktEop;
  assign bus.pkt_is_tlp_o  = r_pktIsTlp;
  assign bus.pkt_seq_o     = r_pktSeq;
  assign bus.outstanding_o = w_outstanding;
  assign bus.proto_err_o   = r_protoErr;

endmodule

// File: tb/tb_dll_tx_scheduler.sv
// Scoreboard bench for dll_tx_scheduler: stimulus pushes hand-computed beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_dll_tx_scheduler;
  localparam int W  = 256;
  localparam int SW = 12;

  typedef struct packed {
    logic [W-1:0]  data;
    logic          sop;
    logic          eop;
    logic          isTlp;
    logic [SW-1:0] seq;
  } beat_t;

  logic  sclk = 1'b0;
  logic  srst_n;
  beat_t expQ[$];
  beat_t monCur;
  beat_t monExp;
  beat_t prevBeat;
  logic  prevHold = 1'b0;
  int    assertCount = 0;
  int    failCount = 0;

  always #5 sclk = ~sclk;

  dll_tx_scheduler_if #(.PIPE_DATA_WIDTH(W), .SEQ_WIDTH(SW)) bus ();

  dll_tx_scheduler #(
    .PIPE_DATA_WIDTH(W), .SEQ_WIDTH(SW),
    .MAX_OUTSTANDING(64), .DLLP_STARVE_LIMIT(4)
  ) dut (
    .sclk(sclk), .srst_n(srst_n), .bus(bus)
  );

  function automatic logic [W-1:0] beatData(input int tag, input int b);
    return {192'(tag * 7 + 3), 32'(tag), 32'(b)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: compares each accepted beat with the queue head and checks that a
  // stalled beat stays unchanged on the next cycle.
  always @(negedge sclk) begin
    monCur = {bus.pkt_data_o, bus.pkt_sop_o, bus.pkt_eop_o, bus.pkt_is_tlp_o, bus.pkt_seq_o};
    if (!srst_n) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        assertCount++;
        if (!bus.pkt_valid_o || monCur !== prevBeat) begin
          failCount++;
          $display("[TB] FAIL hold_stable: got valid=%0b seq=%0d sop=%0b eop=%0b, expected valid=1 seq=%0d sop=%0b eop=%0b",
                   bus.pkt_valid_o, monCur.seq, monCur.sop, monCur.eop, prevBeat.seq, prevBeat.sop, prevBeat.eop);
        end
      end
      if (bus.pkt_valid_o && bus.pkt_ready_i) begin
        assertCount++;
        if (expQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL unexpected_beat: got seq=%0d tlp=%0b data=%0h, expected no beat",
                   monCur.seq, monCur.isTlp, monCur.data);
        end else begin
          monExp = expQ.pop_front();
          if (monCur !== monExp) begin
            failCount++;
            $display("[TB] FAIL beat_compare: got seq=%0d sop=%0b eop=%0b tlp=%0b data=%0h, expected seq=%0d sop=%0b eop=%0b tlp=%0b data=%0h",
                     monCur.seq, monCur.sop, monCur.eop, monCur.isTlp, monCur.data,
                     monExp.seq, monExp.sop, monExp.eop, monExp.isTlp, monExp.data);
          end
        end
      end
      prevHold = bus.pkt_valid_o && !bus.pkt_ready_i && bus.link_up_i;
      prevBeat = monCur;
    end
  end

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic pushExp(input logic [W-1:0] d, input logic s, input logic e, input logic t, input logic [SW-1:0] q);
    beat_t x;
    x.data = d; x.sop = s; x.eop = e; x.isTlp = t; x.seq = q;
    expQ.push_back(x);
  endtask

  task automatic driveTlpBeat(input logic [W-1:0] d, input logic s, input logic e);
    int n;
    n = 0;
    bus.tlp_valid_i = 1'b1; bus.tlp_data_i = d; bus.tlp_sop_i = s; bus.tlp_eop_i = e;
    @(negedge sclk);
    while (!bus.tlp_ready_o && n < 200) begin
      n++;
      @(negedge sclk);
    end
    checkOutput("tlp_accept", 64'(bus.tlp_ready_o), 64'd1);
    tick;
    bus.tlp_valid_i = 1'b0; bus.tlp_sop_i = 1'b0; bus.tlp_eop_i = 1'b0;
  endtask

  task automatic sendTlp(input int nBeats, input logic [SW-1:0] seq, input int tag);
    for (int b = 0; b < nBeats; b++)
      pushExp(beatData(tag, b), b == 0, b == nBeats - 1, 1'b1, seq);
    for (int b = 0; b < nBeats; b++)
      driveTlpBeat(beatData(tag, b), b == 0, b == nBeats - 1);
  endtask

  task automatic sendAck(input logic [SW-1:0] seq);
    bus.ack_valid_i = 1'b1; bus.ack_seq_i = seq;
    tick;
    bus.ack_valid_i = 1'b0;
  endtask

  task automatic waitDrain;
    int n;
    n = 0;
    @(negedge sclk);
    while (expQ.size() != 0 && n < 500) begin
      n++;
      @(negedge sclk);
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
    tick;
  endtask

  task automatic checkOutstanding(input string name, input int expected);
    @(negedge sclk);
    checkOutput(name, 64'(bus.outstanding_o), 64'(expected));
    tick;
  endtask

  task automatic doReset;
    srst_n = 1'b0;
    bus.link_up_i = 1'b1; bus.pkt_ready_i = 1'b1;
    bus.tlp_valid_i = 1'b1; bus.tlp_sop_i = 1'b1; bus.tlp_eop_i = 1'b1; bus.tlp_data_i = '0;
    bus.dllp_valid_i = 1'b1; bus.dllp_data_i = '0;
    bus.ack_valid_i = 1'b0; bus.ack_seq_i = '0;
    repeat (2) tick;
    @(negedge sclk);
    checkOutput("rst_pkt_valid", 64'(bus.pkt_valid_o), 64'd0);
    checkOutput("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
    checkOutput("rst_tlp_ready", 64'(bus.tlp_ready_o), 64'd0);
    checkOutput("rst_dllp_ready", 64'(bus.dllp_ready_o), 64'd0);
    checkOutput("rst_proto_err", 64'(bus.proto_err_o), 64'd0);
    tick;
    bus.tlp_valid_i = 1'b0; bus.tlp_sop_i = 1'b0; bus.tlp_eop_i = 1'b0; bus.dllp_valid_i = 1'b0;
    srst_n = 1'b1;
    tick;
  endtask

  task automatic applyStimulus;
    int  dIdx;
    logic tlpDone, gotD, gotT;

    // Basic 3-beat TLP then a single-beat TLP
    doReset();
    sendTlp(3, 12'd0, 1);
    @(negedge sclk);
    checkOutput("latency_valid", 64'(bus.pkt_valid_o), 64'd1);
    checkOutput("latency_eop", 64'(bus.pkt_eop_o), 64'd1);
    tick;
    sendTlp(1, 12'd1, 2);
    waitDrain();
    checkOutstanding("two_outstanding", 2);
    sendAck(12'd1);
    checkOutstanding("ack_all", 0);

    // DLLP starvation limit: expected order D0..D3, TLP seq 2, D4, D5
    for (int i = 0; i < 4; i++) pushExp(W'(64'hD000 + i), 1'b1, 1'b1, 1'b0, 12'd0);
    pushExp(beatData(20, 0), 1'b1, 1'b1, 1'b1, 12'd2);
    for (int i = 4; i < 6; i++) pushExp(W'(64'hD000 + i), 1'b1, 1'b1, 1'b0, 12'd0);
    dIdx = 0; tlpDone = 1'b0;
    bus.tlp_valid_i = 1'b1; bus.tlp_sop_i = 1'b1; bus.tlp_eop_i = 1'b1; bus.tlp_data_i = beatData(20, 0);
    bus.dllp_valid_i = 1'b1; bus.dllp_data_i = 64'hD000;
    for (int c = 0; c < 40 && (dIdx < 6 || !tlpDone); c++) begin
      @(negedge sclk);
      gotD = bus.dllp_ready_o; gotT = bus.tlp_ready_o;
      tick;
      if (gotD) dIdx++;
      if (gotT) begin
        tlpDone = 1'b1;
        bus.tlp_valid_i = 1'b0; bus.tlp_sop_i = 1'b0; bus.tlp_eop_i = 1'b0;
      end
      bus.dllp_valid_i = (dIdx < 6);
      bus.dllp_data_i  = 64'hD000 + 64'(dIdx);
    end
    bus.dllp_valid_i = 1'b0;
    checkOutput("starve_dllp_count", 64'(dIdx), 64'd6);
    checkOutput("starve_tlp_done", 64'(tlpDone), 64'd1);
    waitDrain();
    sendAck(12'd2);
    checkOutstanding("starve_ack", 0);

    // Replay window full
    doReset();
    for (int i = 0; i < 64; i++) sendTlp(1, SW'(i), 100 + i);
    checkOutstanding("win_full_count", 64);
    pushExp(W'(64'hF00D), 1'b1, 1'b1, 1'b0, 12'd0);
    pushExp(beatData(164, 0), 1'b1, 1'b1, 1'b1, 12'd64);
    bus.tlp_valid_i = 1'b1; bus.tlp_sop_i = 1'b1; bus.tlp_eop_i = 1'b1; bus.tlp_data_i = beatData(164, 0);
    bus.dllp_valid_i = 1'b1; bus.dllp_data_i = 64'hF00D;
    @(negedge sclk);
    checkOutput("win_full_stall", 64'(bus.tlp_ready_o), 64'd0);
    checkOutput("win_full_dllp", 64'(bus.dllp_ready_o), 64'd1);
    tick;
    bus.dllp_valid_i = 1'b0;
    @(negedge sclk);
    checkOutput("win_full_stall2", 64'(bus.tlp_ready_o), 64'd0);
    tick;
    bus.ack_valid_i = 1'b1; bus.ack_seq_i = 12'd9;
    @(negedge sclk);
    checkOutput("win_full_stall3", 64'(bus.tlp_ready_o), 64'd0);
    tick;
    bus.ack_valid_i = 1'b0;
    @(negedge sclk);
    checkOutput("ack_partial", 64'(bus.outstanding_o), 64'd54);
    checkOutput("win_reopen", 64'(bus.tlp_ready_o), 64'd1);
    tick;
    bus.tlp_valid_i = 1'b0; bus.tlp_sop_i = 1'b0; bus.tlp_eop_i = 1'b0;
    checkOutstanding("win_after_grant", 55);
    waitDrain();

    // Sequence wrap: advance next_seq to 4094 with periodic Acks
    doReset();
    for (int i = 0; i < 4094; i++) begin
      sendTlp(1, SW'(i), i);
      if (i % 32 == 31) sendAck(SW'(i));
    end
    sendAck(12'd4093);
    checkOutstanding("preload_outstanding", 0);
    sendTlp(1, 12'd4094, 5000);
    sendTlp(1, 12'd4095, 5001);
    sendTlp(1, 12'd0, 5002);
    checkOutstanding("wrap_outstanding", 3);
    sendAck(12'd4095);
    checkOutstanding("wrap_ack", 1);
    sendAck(12'd4095);
    checkOutstanding("dup_ack_ignored", 1);
    waitDrain();

    // Backpressure mid-TLP for five cycles
    fork
      sendTlp(4, 12'd1, 500);
      begin
        repeat (2) tick;
        bus.pkt_ready_i = 1'b0;
        @(negedge sclk);
        checkOutput("stall_valid", 64'(bus.pkt_valid_o), 64'd1);
        repeat (5) tick;
        bus.pkt_ready_i = 1'b1;
      end
    join
    waitDrain();

    // Link drop on beat 1 of a 4-beat TLP
    pushExp(beatData(600, 0), 1'b1, 1'b0, 1'b1, 12'd2);
    driveTlpBeat(beatData(600, 0), 1'b1, 1'b0);
    bus.link_up_i = 1'b0;
    bus.tlp_valid_i = 1'b1; bus.tlp_data_i = beatData(600, 1);
    bus.dllp_valid_i = 1'b1; bus.dllp_data_i = 64'h1234;
    @(negedge sclk);
    checkOutput("link_down_tlp_ready", 64'(bus.tlp_ready_o), 64'd0);
    checkOutput("link_down_dllp_ready", 64'(bus.dllp_ready_o), 64'd0);
    tick;
    @(negedge sclk);
    checkOutput("link_down_flush", 64'(bus.pkt_valid_o), 64'd0);
    checkOutput("link_down_outstanding", 64'(bus.outstanding_o), 64'd0);
    tick;
    bus.tlp_valid_i = 1'b0; bus.dllp_valid_i = 1'b0; bus.link_up_i = 1'b1;
    tick;
    driveTlpBeat(beatData(601, 2), 1'b0, 1'b0);
    @(negedge sclk);
    checkOutput("stray_proto_err", 64'(bus.proto_err_o), 64'd1);
    checkOutput("stray_dropped", 64'(bus.pkt_valid_o), 64'd0);
    tick;
    @(negedge sclk);
    checkOutput("proto_err_pulse", 64'(bus.proto_err_o), 64'd0);
    tick;
    sendTlp(2, 12'd0, 602);
    checkOutstanding("relink_outstanding", 1);

    // Unexpected sop inside a TLP is forwarded as data and flagged
    pushExp(beatData(603, 0), 1'b1, 1'b0, 1'b1, 12'd1);
    pushExp(beatData(603, 1), 1'b0, 1'b1, 1'b1, 12'd1);
    driveTlpBeat(beatData(603, 0), 1'b1, 1'b0);
    driveTlpBeat(beatData(603, 1), 1'b1, 1'b1);
    @(negedge sclk);
    checkOutput("midsop_proto_err", 64'(bus.proto_err_o), 64'd1);
    tick;
    waitDrain();
    checkOutstanding("final_outstanding", 2);
  endtask

  // Main sequence
  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Watchdog in case a handshake never completes
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dll_tx_scheduler.md
Name: dll_tx_scheduler

Overview:
- Data Link Layer transmit scheduler that sits between the Transaction Layer and the DLL packetizer (SEQ + LCRC insertion).
- Arbitrates between multi-beat TLPs from the TL and single-beat DLLPs (Ack/Nak, UpdateFC) onto one registered PIPE-width beat stream.
- Assigns 12-bit sequence numbers to TLPs.
- Throttles new TLPs when the unacknowledged (replay) window is full, and frees window entries on received Acks.

Parameters:
- PIPE_DATA_WIDTH, 256, beat width of TLP input and packet output.
- SEQ_WIDTH, 12, sequence number width; arithmetic is modulo 2^SEQ_WIDTH.
- MAX_OUTSTANDING, 64, maximum unacknowledged TLPs (replay window depth).
- DLLP_STARVE_LIMIT, 4, maximum consecutive DLLP grants while a TLP SOP is waiting.

Ports:
- sclk  in  1  clock
- srst_n  in  1  synchronous active-low reset
- link_up_i  in  1  DL_Active; low aborts traffic and reinitialises sequence state
- tlp_valid_i  in  1  TLP beat valid
- tlp_ready_o  out  1  TLP beat accepted when valid&ready
- tlp_data_i  in  PIPE_DATA_WIDTH  TLP beat
- tlp_sop_i  in  1  first beat of TLP
- tlp_eop_i  in  1  last beat of TLP
- dllp_valid_i  in  1  DLLP request
- dllp_ready_o  out  1  DLLP accepted when valid&ready
- dllp_data_i  in  64  DLLP content incl. CRC16, LSB-aligned
- ack_valid_i  in  1  Ack received from RX path
- ack_seq_i  in  SEQ_WIDTH  AckNak_Seq_Num
- pkt_valid_o  out  1  output beat valid
- pkt_ready_i  in  1  packetizer accepts beat
- pkt_data_o  out  PIPE_DATA_WIDTH  output beat
- pkt_sop_o  out  1  first beat
- pkt_eop_o  out  1  last beat
- pkt_is_tlp_o  out  1  1 = TLP (packetizer adds SEQ/LCRC), 0 = DLLP
- pkt_seq_o  out  SEQ_WIDTH  sequence number of TLP; 0 for DLLP
- outstanding_o  out  SEQ_WIDTH  unacknowledged TLP count
- proto_err_o  out  1  one-cycle pulse on framing violation

Behaviour:
- Reset: all outputs 0; next_seq = 0; acked_seq = all-ones (4095); outstanding_o = 0; state = S_IDLE; starve counter = 0.
- Output stage:
  - A single register holds each beat; 1-cycle latency from input acceptance to pkt_valid_o.
  - The register is free when !pkt_valid_o || pkt_ready_i.
  - The output beat is held stable while pkt_valid_o && !pkt_ready_i.
- FSM states:
  - S_IDLE: packet boundary; arbitration happens here.
  - S_TLP: mid-TLP; only TLP beats are forwarded, with no DLLP interleave.
- Arbitration, in S_IDLE, only when the register is free and link_up_i = 1:
  - tlp_start = tlp_valid_i & tlp_sop_i & (outstanding_o < MAX_OUTSTANDING).
  - DLLP has priority over TLP, unless tlp_start and starve counter == DLLP_STARVE_LIMIT; then the TLP wins.
  - Starve counter increments on each DLLP grant while tlp_start = 1. It clears on a TLP grant, or when tlp_start = 0.
- DLLP grant:
  - dllp_ready_o = 1.
  - Output beat: data zero-extended, sop = eop = 1, is_tlp = 0, seq = 0.
  - State stays S_IDLE.
- TLP SOP grant:
  - tlp_ready_o = 1; pkt_seq_o = next_seq.
  - next_seq += 1 (wraps 4095→0); outstanding_o += 1.
  - If eop is set on the same beat, stay S_IDLE; else go to S_TLP.
- S_TLP:
  - tlp_ready_o = register free & link_up_i.
  - Each beat is forwarded with is_tlp = 1 and the same pkt_seq_o; sop is forced 0.
  - A beat with eop returns the FSM to S_IDLE.
  - A beat with sop = 1 in S_TLP pulses proto_err_o and is forwarded as data.
- S_IDLE, TLP beat without sop: consumed (tlp_ready_o = 1) and dropped; proto_err_o pulses. This takes priority over DLLP.
- Window full (outstanding_o == MAX_OUTSTANDING):
  - No new TLP starts; a TLP already in S_TLP completes.
  - DLLPs are unaffected.
- Ack handling:
  - d = (next_seq − 1 − ack_seq) mod 2^SEQ_WIDTH.
  - Valid if d < outstanding_o: acked_seq ← ack_seq; outstanding_o ← d.
  - Otherwise the Ack is ignored (stale or duplicate), with no error.
  - Simultaneous Ack and TLP SOP grant: outstanding_o = d + 1, where d is computed with the pre-increment next_seq.
- outstanding_o is always (next_seq − acked_seq − 1) mod 2^SEQ_WIDTH.
- link_up_i low, any cycle including mid-TLP:
  - Next cycle: state S_IDLE; pkt_valid_o = 0 (output beat discarded); next_seq = 0; acked_seq = 4095; outstanding_o = 0; starve counter = 0.
  - tlp_ready_o = dllp_ready_o = 0 while link_up_i is low.
  - Upstream must restart a TLP at sop.

Test Plan:
- Reset, link up, 3-beat TLP (sop on beat 0, eop on beat 2), pkt_ready_i = 1 → three pkt beats 1 cycle later; seq = 0, sop only on the first, eop only on the last; next TLP gets seq 1; outstanding_o = 2.
- DLLP and TLP SOP both valid, DLLP held continuously → 4 DLLPs, then the TLP is granted, then DLLPs resume; pkt_is_tlp_o pattern 0,0,0,0,1.
- Send 64 single-beat TLPs without Ack → 65th TLP stalls (tlp_ready_o = 0), DLLPs still pass. Ack seq 9 → outstanding_o = 54, TLP 64 granted with seq 64.
- Preload next_seq to 4094 via 4094 acked TLPs; send 3 TLPs → seqs 4094, 4095, 0. Ack 4095 → outstanding_o = 1. Duplicate Ack 4095 → ignored.
- pkt_ready_i = 0 for 5 cycles mid-TLP → pkt_data_o/sop/eop/seq held stable; no beat loss or duplication.
- link_up_i dropped on beat 1 of a 4-beat TLP → pkt_valid_o = 0 next cycle, outstanding_o = 0. After link_up_i is restored, the next TLP gets seq 0. A non-sop beat in S_IDLE pulses proto_err_o for one cycle.
